// File: rtl/axi_lite_to_mem_bridge_pkg.sv
// Shared types and constants for the AXI-Lite slave to req/gnt memory bridge.
// Response codes follow the AXI encoding so the bus side can use them directly.
package axi_lite_to_mem_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    SEL_READ  = 1'b0,
    SEL_WRITE = 1'b1
  } sel_e;

  // ST_HOLD: a request is on the memory port and waiting for its grant.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } req_state_e;

  function automatic logic [1:0] resp_from_err(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_to_mem_bridge_if.sv
// Bundles the AXI-Lite slave channels and the req/gnt/rsp memory port.
// Signal directions in the names are as seen from the bridge.
interface axi_lite_to_mem_bridge_if #(
  parameter int AxiAddrWidth = 32,
  parameter int MemAddrWidth = 32,
  parameter int DataWidth    = 32
);
  localparam int StrbWidth = DataWidth / 8;

  logic [AxiAddrWidth-1:0] aw_addr_i;
  logic                    aw_valid_i;
  logic                    aw_ready_o;
  logic [DataWidth-1:0]    w_data_i;
  logic [StrbWidth-1:0]    w_strb_i;
  logic                    w_valid_i;
  logic                    w_ready_o;
  logic [1:0]              b_resp_o;
  logic                    b_valid_o;
  logic                    b_ready_i;
  logic [AxiAddrWidth-1:0] ar_addr_i;
  logic                    ar_valid_i;
  logic                    ar_ready_o;
  logic [DataWidth-1:0]    r_data_o;
  logic [1:0]              r_resp_o;
  logic                    r_valid_o;
  logic                    r_ready_i;

  logic                    mem_req_o;
  logic                    mem_gnt_i;
  logic [MemAddrWidth-1:0] mem_addr_o;
  logic                    mem_we_o;
  logic [DataWidth-1:0]    mem_wdata_o;
  logic [StrbWidth-1:0]    mem_be_o;
  logic                    mem_rsp_valid_i;
  logic [DataWidth-1:0]    mem_rsp_rdata_i;
  logic                    mem_rsp_error_i;

  modport slave (
    input  aw_addr_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i, b_ready_i,
    input  ar_addr_i, ar_valid_i, r_ready_i,
    output aw_ready_o, w_ready_o, b_resp_o, b_valid_o, ar_ready_o,
    output r_data_o, r_resp_o, r_valid_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o,
    input  mem_gnt_i, mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_error_i
  );

  modport master (
    output aw_addr_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i, b_ready_i,
    output ar_addr_i, ar_valid_i, r_ready_i,
    input  aw_ready_o, w_ready_o, b_resp_o, b_valid_o, ar_ready_o,
    input  r_data_o, r_resp_o, r_valid_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o,
    output mem_gnt_i, mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_error_i
  );

endinterface

// File: rtl/axi_lite_to_mem_bridge_sync_fifo.sv
// Small register-based FIFO with registered state and combinational head output.
// Pushes into a full FIFO and pops from an empty one are ignored.
module axi_lite_to_mem_bridge_sync_fifo #(
  parameter int Width = 1,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntWidth = $clog2(Depth + 1);

  logic [Width-1:0]    r_mem [Depth];
  logic [PtrWidth-1:0] r_wptr;
  logic [PtrWidth-1:0] r_rptr;
  logic [CntWidth-1:0] r_count;
  logic                w_push;
  logic                w_pop;

  assign full_o  = (r_count == CntWidth'(Depth));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= (r_wptr == PtrWidth'(Depth - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PtrWidth'(Depth - 1)) ? '0 : r_rptr + 1'b1;
      end
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_to_mem_bridge.sv
// AXI-Lite slave that issues single-beat req/gnt memory requests and returns
// the in-order memory responses on B or R, limited to MaxRequests in flight.
module axi_lite_to_mem_bridge
  import axi_lite_to_mem_bridge_pkg::*;
#(
  parameter int AxiAddrWidth = 32,
  parameter int MemAddrWidth = 32,
  parameter int DataWidth    = 32,
  parameter int MaxRequests  = 2
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  axi_lite_to_mem_bridge_if.slave bus
);
  localparam int StrbWidth = DataWidth / 8;
  localparam int RspWidth  = DataWidth + 1;

  logic                    r_active;
  logic                    r_aw_full;
  logic [AxiAddrWidth-1:0] r_aw_addr;
  logic                    r_w_full;
  logic [DataWidth-1:0]    r_w_data;
  logic [StrbWidth-1:0]    r_w_strb;
  logic                    r_ar_full;
  logic [AxiAddrWidth-1:0] r_ar_addr;
  logic                    r_prio_read;
  req_state_e              r_state;
  req_state_e              w_state_next;
  sel_e                    r_sel;
  sel_e                    w_sel;

  logic w_aw_ready, w_w_ready, w_ar_ready;
  logic w_wr_cand, w_rd_cand, w_req, w_grant, w_grant_wr, w_grant_rd;
  logic w_order_full, w_order_empty, w_order_we;
  logic w_rsp_full, w_rsp_empty, w_rsp_push, w_rsp_hs;
  logic [RspWidth-1:0] w_rsp_head;
  logic w_b_valid, w_r_valid;

  // Readies stay low until the first clock after reset release.
  assign w_aw_ready = r_active && !r_aw_full;
  assign w_w_ready  = r_active && !r_w_full;
  assign w_ar_ready = r_active && !r_ar_full;
  assign w_wr_cand  = r_aw_full && r_w_full;
  assign w_rd_cand  = r_ar_full;

  // Selection is frozen in ST_HOLD; candidates and FIFO space cannot drop
  // there because both only change on a grant.
  always_comb begin
    w_state_next = r_state;
    w_sel        = r_sel;
    w_req        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_sel = (w_wr_cand && (!w_rd_cand || !r_prio_read)) ? SEL_WRITE : SEL_READ;
        w_req = (w_wr_cand || w_rd_cand) && !w_order_full;
        if (w_req && !bus.mem_gnt_i) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        w_req = 1'b1;
        if (bus.mem_gnt_i) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_grant    = w_req && bus.mem_gnt_i;
  assign w_grant_wr = w_grant && (w_sel == SEL_WRITE);
  assign w_grant_rd = w_grant && (w_sel == SEL_READ);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_sel       <= SEL_READ;
      r_prio_read <= 1'b1;
      r_active    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_sel    <= w_sel;
      r_active <= 1'b1;
      if (w_grant) r_prio_read <= (w_sel == SEL_WRITE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_ar_full <= 1'b0;
      r_ar_addr <= '0;
    end else begin
      if (bus.aw_valid_i && w_aw_ready) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= bus.aw_addr_i;
      end else if (w_grant_wr) begin
        r_aw_full <= 1'b0;
      end
      if (bus.w_valid_i && w_w_ready) begin
        r_w_full <= 1'b1;
        r_w_data <= bus.w_data_i;
        r_w_strb <= bus.w_strb_i;
      end else if (w_grant_wr) begin
        r_w_full <= 1'b0;
      end
      if (bus.ar_valid_i && w_ar_ready) begin
        r_ar_full <= 1'b1;
        r_ar_addr <= bus.ar_addr_i;
      end else if (w_grant_rd) begin
        r_ar_full <= 1'b0;
      end
    end
  end

  assign bus.aw_ready_o  = w_aw_ready;
  assign bus.w_ready_o   = w_w_ready;
  assign bus.ar_ready_o  = w_ar_ready;
  assign bus.mem_req_o   = w_req;
  assign bus.mem_we_o    = (w_sel == SEL_WRITE);
  assign bus.mem_addr_o  = (w_sel == SEL_WRITE) ? r_aw_addr[MemAddrWidth-1:0]
                                                : r_ar_addr[MemAddrWidth-1:0];
  assign bus.mem_wdata_o = (w_sel == SEL_WRITE) ? r_w_data : '0;
  assign bus.mem_be_o    = (w_sel == SEL_WRITE) ? r_w_strb : '1;

  axi_lite_to_mem_bridge_sync_fifo #(.Width(1), .Depth(MaxRequests)) i_order_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_grant),
    .data_i  (bus.mem_we_o),
    .pop_i   (w_rsp_hs),
    .data_o  (w_order_we),
    .full_o  (w_order_full),
    .empty_o (w_order_empty)
  );

  // A response with nothing outstanding is dropped.
  assign w_rsp_push = bus.mem_rsp_valid_i && !w_order_empty;

  axi_lite_to_mem_bridge_sync_fifo #(.Width(RspWidth), .Depth(MaxRequests)) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_rsp_push),
    .data_i  ({bus.mem_rsp_rdata_i, bus.mem_rsp_error_i}),
    .pop_i   (w_rsp_hs),
    .data_o  (w_rsp_head),
    .full_o  (w_rsp_full),
    .empty_o (w_rsp_empty)
  );

  assign w_b_valid = !w_rsp_empty && w_order_we;
  assign w_r_valid = !w_rsp_empty && !w_order_we;
  assign w_rsp_hs  = (w_b_valid && bus.b_ready_i) || (w_r_valid && bus.r_ready_i);

  assign bus.b_valid_o = w_b_valid;
  assign bus.r_valid_o = w_r_valid;
  assign bus.b_resp_o  = w_b_valid ? resp_from_err(w_rsp_head[0]) : RESP_OKAY;
  assign bus.r_resp_o  = w_r_valid ? resp_from_err(w_rsp_head[0]) : RESP_OKAY;
  assign bus.r_data_o  = w_r_valid ? w_rsp_head[RspWidth-1:1] : '0;

  a_rsp_without_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus.mem_rsp_valid_i && w_order_empty));
  a_rsp_fifo_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_rsp_push && w_rsp_full && !w_rsp_hs));
  a_no_decerr: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.b_resp_o != RESP_DECERR) && (bus.r_resp_o != RESP_DECERR));

endmodule

// File: doc/axi_lite_to_mem_bridge.md
Name: axi_lite_to_mem_bridge

Overview:
AXI4-Lite slave that turns AXI-Lite reads and writes into single-beat requests on the team's req/gnt/rsp_valid memory interface. It is the mirror of the mem-to-AXI-Lite master: it terminates an AXI-Lite bus and drives a memory or register file. It tracks in-order outstanding requests and returns responses on R or B in request order.

Parameters:
AxiAddrWidth, 32, AXI-Lite address width
MemAddrWidth, 32, memory address width; must be ≤ AxiAddrWidth; the AXI address is truncated to its LSBs
DataWidth, 32, data width, a multiple of 8; strobe and be width is DataWidth/8
MaxRequests, 2, maximum number of granted memory requests whose AXI response has not yet completed; ≥ 1

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
aw_addr_i  in  AxiAddrWidth  AW address
aw_valid_i / aw_ready_o  in/out  1  AW handshake
w_data_i  in  DataWidth  W data
w_strb_i  in  DataWidth/8  W strobes
w_valid_i / w_ready_o  in/out  1  W handshake
b_resp_o  out  2  B response
b_valid_o / b_ready_i  out/in  1  B handshake
ar_addr_i  in  AxiAddrWidth  AR address
ar_valid_i / ar_ready_o  in/out  1  AR handshake
r_data_o  out  DataWidth  R data
r_resp_o  out  2  R response
r_valid_o / r_ready_i  out/in  1  R handshake
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory grant
mem_addr_o  out  MemAddrWidth  request address
mem_we_o  out  1  1 = write
mem_wdata_o  out  DataWidth  write data
mem_be_o  out  DataWidth/8  byte enables
mem_rsp_valid_i  in  1  response valid; exactly one per grant, in order, at least 1 cycle after its grant
mem_rsp_rdata_i  in  DataWidth  read data; ignored for writes
mem_rsp_error_i  in  1  response error

Behaviour:
- Clock is clk_i. Reset is rst_ni, asynchronous, active-low.
- Reset values:
  - all *_ready_o, b_valid_o, r_valid_o and mem_req_o are 0.
  - Data outputs are 0.
  - Holding registers are empty; FIFOs are empty; arbitration priority is on read.
- Input holding registers:
  - AW, W and AR each have a single-entry register.
  - x_ready_o = !x_full_q. There is no bypass, so a register cannot be refilled in the cycle it is consumed.
  - AW and W are captured independently, in any order or in the same cycle.
- Write candidate: aw_full_q && w_full_q. Read candidate: ar_full_q.
- Arbitration:
  - If only one candidate exists, it is selected.
  - If both exist, the side holding priority is selected.
  - On each grant, priority moves to the other side (round-robin).
- Issue rule: mem_req_o = candidate && !order_full.
  - A full order FIFO blocks issue even when an AXI response pops in the same cycle.
- Request lock: once mem_req_o is asserted, the selection and all mem_* fields stay stable until mem_gnt_i.
  - A newly arriving other-type request does not change the selection.
- Request latency: an AR handshake in cycle N gives mem_req_o in cycle N+1 at the earliest.
- Request fields:
  - mem_addr_o = addr[MemAddrWidth-1:0].
  - Writes: mem_wdata_o = w_data, mem_be_o = w_strb, mem_we_o = 1.
  - Reads: mem_be_o is all-ones, mem_we_o = 0.
- On grant (mem_req_o && mem_gnt_i):
  - The consumed holding register(s) are cleared; for a write, AW and W clear together.
  - mem_we_o is pushed into the order FIFO (depth MaxRequests).
- On mem_rsp_valid_i: {rdata, error} is pushed into the response FIFO (depth MaxRequests, not fall-through).
  - This FIFO cannot overflow because of the order-FIFO credit limit.
- Response output:
  - The head of the response FIFO is presented when it is non-empty.
  - The head of the order FIFO selects B (type 1) or R (type 0).
  - The valid on the unselected channel is 0.
  - resp = error ? 2'b10 (SLVERR) : 2'b00 (OKAY). r_data_o = rdata; it is 0 for writes.
  - Response latency: mem_rsp_valid_i in cycle N gives valid in cycle N+1.
- On a B or R handshake, both FIFOs pop together.
- Simultaneous events:
  - Grant and response handshake in the same cycle: the order FIFO pushes and pops, and its usage is unchanged.
  - mem_rsp_valid_i and a pop in the same cycle: both take effect.
- mem_rsp_valid_i with an empty order FIFO is a protocol violation: it is ignored in RTL and flagged by an assertion.
- Reset mid-operation: all state clears immediately. In-flight memory responses are lost, and the environment must also reset the memory.

Decomposition:
- Shared axi_pkg: RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
- One sub-module: bridge_sync_fifo, a parameterised width and depth FIFO with full_o, empty_o, push_i, pop_i and data ports.
  - It is instantiated twice: order FIFO with width 1, response FIFO with width DataWidth+1.

Test Plan:
- Read: AR addr 0x40 at cycle 0, gnt immediate, rsp at cycle 3 with rdata 0xDEADBEEF, err 0 -> mem_req_o/we 0/addr 0x40 at cycle 1; R at cycle 4 with data 0xDEADBEEF, resp OKAY.
- Write, W before AW: W 0x12345678 strb 4'b0011 at cycle 0, AW 0x80 at cycle 2 -> mem_req_o at cycle 3 with we 1, be 0011; B OKAY one cycle after rsp; w_ready_o is 0 during cycles 1-3.
- Arbitration: write and read both pending, gnt always 1 -> issue order read, write, read; priority alternates across grants.
- Credit limit (MaxRequests=2): three reads with mem_rsp_valid_i held low -> third mem_req_o stays 0 until the first R handshake completes and frees the FIFO; r_ready_i low stalls r_valid_o stable.
- Error: write whose response has mem_rsp_error_i=1 -> b_resp_o = 2'b10; a subsequent read with err 0 -> r_resp_o = 2'b00.
- Reset: assert rst_ni low while mem_req_o is high with one request outstanding -> all valids and readies are 0 during reset; after release, a clean read completes with no stale B or R.
